// File: rtl/regfile_stk.sv
// NREGS x DATA_W register file (r0 hardwired to zero) with a circular return-address stack.
// Optional REGFILE_BYPASS_EN: same-cycle forwarding of wd to rd1/rd2 and of pc to ret_addr.
module regfile_stk #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NREGS     = 8,
    parameter int unsigned STK_DEPTH = 4,
    localparam int unsigned ADDR_W   = $clog2(NREGS),
    localparam int unsigned SP_W     = $clog2(STK_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [DATA_W-1:0] pc,
    input  logic              call,
    input  logic              ret,
    output logic [DATA_W-1:0] ret_addr,
    output logic [SP_W:0]     stk_cnt,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              ovf,
    output logic              unf,
    input  logic              clr_err
);

    localparam int unsigned CNT_W = SP_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STK_DEPTH);

    logic [DATA_W-1:0] rf  [NREGS];
    logic [DATA_W-1:0] stk [STK_DEPTH];
    logic [SP_W-1:0]   tp, tp_nxt, push_idx;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              push, ovf_evt, unf_evt;

    // Combinational read ports; r0 always reads zero
    always_comb begin
        rd1 = (ra1 == '0) ? '0 : rf[ra1];
        rd2 = (ra2 == '0) ? '0 : rf[ra2];
`ifdef REGFILE_BYPASS_EN
        if (we && (wa != '0) && (wa == ra1)) rd1 = wd;
        if (we && (wa != '0) && (wa == ra2)) rd2 = wd;
`endif
    end

    // Top of stack, zero when empty
    always_comb begin
        ret_addr = (stk_cnt == '0) ? '0 : stk[tp];
`ifdef REGFILE_BYPASS_EN
        if (call && ret) ret_addr = pc;
`endif
    end

    // Stack next-state: call+ret on a non-empty stack replaces the top in place
    always_comb begin
        tp_nxt   = tp;
        cnt_nxt  = stk_cnt;
        push     = 1'b0;
        push_idx = tp + SP_W'(1);
        ovf_evt  = 1'b0;
        unf_evt  = 1'b0;
        if (call && ret && (stk_cnt != '0)) begin
            push     = 1'b1;
            push_idx = tp;
        end else if (call) begin
            push   = 1'b1;
            tp_nxt = tp + SP_W'(1);
            if (stk_cnt == CNT_MAX) ovf_evt = 1'b1;
            else                    cnt_nxt = stk_cnt + CNT_W'(1);
            if (ret) unf_evt = 1'b1;
        end else if (ret) begin
            if (stk_cnt != '0) begin
                tp_nxt  = tp - SP_W'(1);
                cnt_nxt = stk_cnt - CNT_W'(1);
            end else begin
                unf_evt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++)     rf[i]  <= '0;
            for (int i = 0; i < int'(STK_DEPTH); i++) stk[i] <= '0;
            tp        <= '0;
            stk_cnt   <= '0;
            stk_full  <= 1'b0;
            stk_empty <= 1'b1;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            if (we && (wa != '0)) rf[wa] <= wd;
            if (push) stk[push_idx] <= pc;
            tp        <= tp_nxt;
            stk_cnt   <= cnt_nxt;
            stk_full  <= (cnt_nxt == CNT_MAX);
            stk_empty <= (cnt_nxt == '0);
            // A new error event wins over a coincident clear
            ovf       <= (ovf & ~clr_err) | ovf_evt;
            unf       <= (unf & ~clr_err) | unf_evt;
        end
    end

endmodule

// File: tb/tb_regfile_stk.sv
// Scoreboard bench for regfile_stk: stimulus queues expected output values, a negedge monitor checks them.
module tb_regfile_stk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int S_RD1 = 0, S_RD2 = 1, S_RET = 2, S_CNT = 3,
                   S_FULL = 4, S_EMPTY = 5, S_OVF = 6, S_UNF = 7;

    typedef struct {
        int          sig;
        logic [15:0] exp;
        string       name;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, call, ret, clr_err;
    logic [2:0]  wa, ra1, ra2;
    logic [15:0] wd, pc;
    logic [15:0] rd1, rd2, ret_addr;
    logic [2:0]  stk_cnt;
    logic        stk_full, stk_empty, ovf, unf;

    chk_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_stk dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .pc(pc), .call(call), .ret(ret), .ret_addr(ret_addr),
        .stk_cnt(stk_cnt), .stk_full(stk_full), .stk_empty(stk_empty),
        .ovf(ovf), .unf(unf), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // Monitor: drain every expectation queued for this cycle, mid-cycle
    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t        e;
            logic [15:0] a;
            e = q.pop_front();
            case (e.sig)
                S_RD1:   a = rd1;
                S_RD2:   a = rd2;
                S_RET:   a = ret_addr;
                S_CNT:   a = 16'(stk_cnt);
                S_FULL:  a = 16'(stk_full);
                S_EMPTY: a = 16'(stk_empty);
                S_OVF:   a = 16'(ovf);
                default: a = 16'(unf);
            endcase
            n_checks++;
            if (a !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h at %0t", e.name, a, e.exp, $time);
            end
        end
    end

    task automatic expect_v(input int sig, input logic [15:0] v, input string name);
        chk_t e;
        e.sig = sig; e.exp = v; e.name = name;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stk_state(input logic [2:0] c, input logic [15:0] top, input string tag);
        expect_v(S_CNT, 16'(c), {tag, "_cnt"});
        expect_v(S_RET, top, {tag, "_ret"});
        expect_v(S_FULL, 16'(c == 3'd4), {tag, "_full"});
        expect_v(S_EMPTY, 16'(c == 3'd0), {tag, "_empty"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; we = 1'b0; call = 1'b0; ret = 1'b0; clr_err = 1'b0;
        wa = '0; ra1 = '0; ra2 = '0; wd = '0; pc = '0;
        step(); step();
        rst_n = 1'b1;

        // Reset state
        ra1 = 3'd3; ra2 = 3'd5;
        expect_v(S_RD1, 16'h0, "rst_rd1");
        expect_v(S_RD2, 16'h0, "rst_rd2");
        stk_state(3'd0, 16'h0, "rst");
        expect_v(S_OVF, 16'h0, "rst_ovf");
        expect_v(S_UNF, 16'h0, "rst_unf");
        step();

        // Write r3 = BEEF
        we = 1'b1; wa = 3'd3; wd = 16'hBEEF;
        expect_v(S_RD1, BYP ? 16'hBEEF : 16'h0, "wr3_same_cycle");
        step();
        // Write to r0 is discarded
        wa = 3'd0; wd = 16'h1234; ra2 = 3'd0;
        expect_v(S_RD1, 16'hBEEF, "wr3_next_cycle");
        expect_v(S_RD2, 16'h0, "wr0_same_cycle");
        step();
        we = 1'b0; ra1 = 3'd0;
        expect_v(S_RD1, 16'h0, "wr0_discarded");
        step();

        // Four calls fill the stack
        call = 1'b1;
        pc = 16'd10; step();
        pc = 16'd20; step();
        pc = 16'd30; step();
        pc = 16'd40; step();
        call = 1'b0;
        stk_state(3'd4, 16'd40, "full4");
        expect_v(S_OVF, 16'h0, "full4_ovf");
        step();
        // Fifth call overwrites the oldest
        call = 1'b1; pc = 16'd50; step();
        call = 1'b0;
        stk_state(3'd4, 16'd50, "ovf");
        expect_v(S_OVF, 16'h1, "ovf_flag");
        step();
        // Four rets return 50, 40, 30, 20
        ret = 1'b1;
        expect_v(S_RET, 16'd50, "pop1"); step();
        expect_v(S_RET, 16'd40, "pop2"); step();
        expect_v(S_RET, 16'd30, "pop3"); step();
        expect_v(S_RET, 16'd20, "pop4"); step();
        ret = 1'b0;
        stk_state(3'd0, 16'h0, "drained");
        clr_err = 1'b1; step();
        clr_err = 1'b0;
        expect_v(S_OVF, 16'h0, "ovf_cleared");
        step();

        // Underflow from empty
        ret = 1'b1;
        expect_v(S_RET, 16'h0, "unf_ret_addr");
        step();
        ret = 1'b0;
        expect_v(S_UNF, 16'h1, "unf_set");
        stk_state(3'd0, 16'h0, "unf");
        clr_err = 1'b1; step();
        clr_err = 1'b0;
        expect_v(S_UNF, 16'h0, "unf_cleared");
        step();
        // Coincident clear and new underflow: set wins
        clr_err = 1'b1; ret = 1'b1; step();
        clr_err = 1'b0; ret = 1'b0;
        expect_v(S_UNF, 16'h1, "unf_set_wins");
        clr_err = 1'b1; step();
        clr_err = 1'b0;

        // Replace top with call+ret
        call = 1'b1;
        pc = 16'd10; step();
        pc = 16'd20; step();
        ret = 1'b1; pc = 16'd99;
        expect_v(S_RET, BYP ? 16'd99 : 16'd20, "replace_same_cycle");
        step();
        call = 1'b0; ret = 1'b0;
        stk_state(3'd2, 16'd99, "replaced");
        expect_v(S_UNF, 16'h0, "replace_no_unf");
        ret = 1'b1; step();
        expect_v(S_RET, 16'd10, "after_replace_pop");
        step();
        ret = 1'b0;
        stk_state(3'd0, 16'h0, "empty_again");
        step();

        // Same-cycle write/read on r5
        we = 1'b1; wa = 3'd5; wd = 16'h1111; ra2 = 3'd5; step();
        wd = 16'hA5A5;
        expect_v(S_RD2, BYP ? 16'hA5A5 : 16'h1111, "byp_same_cycle");
        step();
        we = 1'b0;
        expect_v(S_RD2, 16'hA5A5, "byp_next_cycle");
        step();

        // Reset mid-operation drops the coincident write and push
        we = 1'b1; wa = 3'd3; wd = 16'h7777; call = 1'b1; pc = 16'd77;
        #1 rst_n = 1'b0;
        step();
        we = 1'b0; call = 1'b0;
        rst_n = 1'b1; ra1 = 3'd3;
        expect_v(S_RD1, 16'h0, "midrst_rd1");
        expect_v(S_RD2, 16'h0, "midrst_rd2");
        stk_state(3'd0, 16'h0, "midrst");
        step();

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
